// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin arbiter:
// FSM state encoding, requester index constants and a one-hot helper.
package rr_arbiter4_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [1:0] IDX_A = 2'd3;
    localparam logic [1:0] IDX_B = 2'd2;
    localparam logic [1:0] IDX_C = 2'd1;
    localparam logic [1:0] IDX_D = 2'd0;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority encoder: returns the first eligible index after last_idx,
// wrapping 3->0. Purely combinational.
module rr_pick4 (
    input  logic [3:0] eligible,
    input  logic [1:0] last_idx,
    output logic [1:0] pick,
    output logic       any
);

    logic [7:0] doubled;
    logic [2:0] start;
    logic [3:0] rotated;
    logic [1:0] offset;

    // Bit 0 of rotated is the requester immediately after last_idx.
    assign doubled = {eligible, eligible};
    assign start   = {1'b0, last_idx} + 3'd1;
    assign rotated = doubled[start +: 4];

    always_comb begin
        offset = 2'd0;
        any    = 1'b1;
        unique casez (rotated)
            4'b???1: offset = 2'd0;
            4'b??10: offset = 2'd1;
            4'b?100: offset = 2'd2;
            4'b1000: offset = 2'd3;
            default: any    = 1'b0;
        endcase
    end

    assign pick = last_idx + 2'd1 + offset;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered grant, hold limit and
// forced revoke; a revoked requester stays masked until it drops its request.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout,
    output logic       busy
);

    state_t          state, state_nxt;
    logic [1:0]      last_idx, last_nxt;
    logic [CW-1:0]   hold_cnt, cnt_nxt;
    logic [3:0]      block_mask, mask_nxt, mask_set;
    logic [3:0]      grant_nxt;
    logic [1:0]      idx_nxt;
    logic            valid_nxt, timeout_nxt;
    logic [3:0]      eligible;
    logic [1:0]      pick;
    logic            any;

    assign eligible = req & ~block_mask;

    rr_pick4 u_pick (
        .eligible (eligible),
        .last_idx (last_idx),
        .pick     (pick),
        .any      (any)
    );

    always_comb begin
        state_nxt   = state;
        last_nxt    = last_idx;
        cnt_nxt     = hold_cnt;
        grant_nxt   = grant;
        idx_nxt     = gnt_idx;
        valid_nxt   = gnt_valid;
        timeout_nxt = 1'b0;
        mask_set    = 4'b0000;
        case (state)
            ST_IDLE: begin
                if (any) begin
                    state_nxt = ST_GRANT;
                    grant_nxt = onehot4(pick);
                    idx_nxt   = pick;
                    valid_nxt = 1'b1;
                    cnt_nxt   = CW'(1);
                end
            end
            ST_GRANT: begin
                // A release on the limit cycle wins over the revoke.
                if (!req[gnt_idx] || hold_cnt == CW'(MAX_HOLD)) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = gnt_idx;
                    grant_nxt = 4'b0000;
                    idx_nxt   = 2'd0;
                    valid_nxt = 1'b0;
                    cnt_nxt   = '0;
                    if (req[gnt_idx]) begin
                        timeout_nxt = 1'b1;
                        mask_set    = onehot4(gnt_idx);
                    end
                end else if (hold_cnt != '1) begin
                    cnt_nxt = hold_cnt + CW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        mask_nxt = (block_mask & req) | mask_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_idx   <= IDX_A;
            hold_cnt   <= '0;
            block_mask <= 4'b0000;
            grant      <= 4'b0000;
            gnt_idx    <= IDX_D;
            gnt_valid  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_idx   <= last_nxt;
            hold_cnt   <= cnt_nxt;
            block_mask <= mask_nxt;
            grant      <= grant_nxt;
            gnt_idx    <= idx_nxt;
            gnt_valid  <= valid_nxt;
            timeout    <= timeout_nxt;
        end
    end

    assign busy = gnt_valid;

endmodule
